// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
// Bit indices address the stall/flush vectors: PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB.
package pipe_ctrl_pkg;

  localparam int STALL_W    = 5;
  localparam int REG_ADDR_W = 5;

  localparam int STALL_PC     = 0;
  localparam int STALL_IFID   = 1;
  localparam int STALL_IDEXE  = 2;
  localparam int STALL_EXEMEM = 3;
  localparam int STALL_MEMWB  = 4;

  localparam logic [STALL_W-1:0] HOLD_MEM = 5'b01111;
  localparam logic [STALL_W-1:0] HOLD_DIV = 5'b00111;
  localparam logic [STALL_W-1:0] HOLD_LU  = 5'b00011;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DIV_BUSY = 1'b1
  } pc_state_t;

  function automatic logic [STALL_W-1:0] bubble_at(input int idx);
    logic [STALL_W-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EXE whose rd is read by the instruction in ID.
// x0 is hard-wired zero and never creates a dependency.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  reg1_re,
  input  logic [REG_ADDR_W-1:0] reg1_raddr,
  input  logic                  reg2_re,
  input  logic [REG_ADDR_W-1:0] reg2_raddr,
  input  logic                  is_load,
  input  logic                  reg_we,
  input  logic [REG_ADDR_W-1:0] reg_waddr,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = reg1_re & (reg1_raddr == reg_waddr);
  assign rs2_hit  = reg2_re & (reg2_raddr == reg_waddr);
  assign load_use = is_load & reg_we & (reg_waddr != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for the 5-stage core: load-use, divider sequencing
// with timeout, memory-bus stalls and branch redirects, plus a stall-cycle counter.
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 id_reg1_re_i,
  input  logic [4:0]           id_reg1_raddr_i,
  input  logic                 id_reg2_re_i,
  input  logic [4:0]           id_reg2_raddr_i,
  input  logic                 exe_is_load_i,
  input  logic                 exe_reg_we_i,
  input  logic [4:0]           exe_reg_waddr_i,
  input  logic                 exe_div_req_i,
  input  logic                 div_done_i,
  input  logic                 mem_stall_req_i,
  input  logic                 exe_jump_i,
  input  logic [31:0]          exe_jump_addr_i,
  output logic [4:0]           stall_o,
  output logic [4:0]           flush_o,
  output logic                 pc_redirect_o,
  output logic [31:0]          pc_redirect_addr_o,
  output logic                 div_start_o,
  output logic                 div_err_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  import pipe_ctrl_pkg::*;

  localparam int            TW       = $clog2(DIV_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 2);

  pc_state_t     state;
  logic [TW-1:0] timer;
  logic          load_use;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  pipe_ctrl_hazard_detect u_hazard (
    .reg1_re    (id_reg1_re_i),
    .reg1_raddr (id_reg1_raddr_i),
    .reg2_re    (id_reg2_re_i),
    .reg2_raddr (id_reg2_raddr_i),
    .is_load    (exe_is_load_i),
    .reg_we     (exe_reg_we_i),
    .reg_waddr  (exe_reg_waddr_i),
    .load_use   (load_use)
  );

  // Output priority: mem stall > divider busy > jump > divider launch > load-use.
  // Reset forces every control low, even mid-divide.
  always_comb begin
    stall_o       = '0;
    flush_o       = '0;
    pc_redirect_o = 1'b0;
    div_start_o   = 1'b0;
    if (rst_n_i) begin
      if (mem_stall_req_i) begin
        stall_o = HOLD_MEM;
        flush_o = bubble_at(STALL_MEMWB);
      end else if (state == ST_DIV_BUSY) begin
        if (!div_done_i) begin
          stall_o = HOLD_DIV;
          flush_o = bubble_at(STALL_EXEMEM);
        end
      end else if (exe_jump_i) begin
        pc_redirect_o = 1'b1;
        flush_o       = bubble_at(STALL_IFID) | bubble_at(STALL_IDEXE);
      end else if (exe_div_req_i) begin
        div_start_o = 1'b1;
        stall_o     = HOLD_DIV;
        flush_o     = bubble_at(STALL_EXEMEM);
      end else if (load_use) begin
        stall_o = HOLD_LU;
        flush_o = bubble_at(STALL_IDEXE);
      end
    end
  end

  assign pc_redirect_addr_o = pc_redirect_o ? exe_jump_addr_i : 32'h0;

  // Divider FSM: timer keeps counting through mem stalls; a timeout abandons the
  // divide and leaves a sticky error since EXE commits a stale result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      timer     <= '0;
      div_err_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_start_o) begin
            state <= ST_DIV_BUSY;
            timer <= '0;
          end
        end
        ST_DIV_BUSY: begin
          if (div_done_i) begin
            state <= ST_IDLE;
          end else if (timer == TMO_LAST) begin
            state     <= ST_IDLE;
            div_err_o <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o[STALL_PC]) begin
      stall_cnt_o <= sat_inc(stall_cnt_o);
    end
  end

endmodule
